// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared pipeline types for the hazard scoreboard:
// forward-select codes and mult/div occupancy states.
package hazard_scoreboard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // The memory stage holds the younger result, so it wins over writeback.
  function automatic fwd_sel_e fwd_pick(
    input logic hit_m,
    input logic hit_w
  );
    if (hit_m) return FWD_MEM;
    if (hit_w) return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-to-hazard-unit bundle: stage specifiers and
// controls in, stall/flush/forward selects out.
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic              BranchD;
  logic              MulDivD;
  logic              HiLoRdD;
  logic [REG_AW-1:0] RsD;
  logic [REG_AW-1:0] RtD;
  logic [REG_AW-1:0] RsE;
  logic [REG_AW-1:0] RtE;
  logic [REG_AW-1:0] WriteRegE;
  logic [REG_AW-1:0] WriteRegM;
  logic [REG_AW-1:0] WriteRegW;
  logic              RegWriteE;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              MemtoRegE;
  logic              MemtoRegM;

  logic              StallF;
  logic              StallD;
  logic              FlushE;
  logic              ForwardAD;
  logic              ForwardBD;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              MdBusy;
  logic [CNT_W-1:0]  StallCnt;

  modport master (
    output BranchD, MulDivD, HiLoRdD,
    output RsD, RtD, RsE, RtE,
    output WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW,
    output MemtoRegE, MemtoRegM,
    input  StallF, StallD, FlushE,
    input  ForwardAD, ForwardBD,
    input  ForwardAE, ForwardBE,
    input  MdBusy, StallCnt
  );

  modport slave (
    input  BranchD, MulDivD, HiLoRdD,
    input  RsD, RtD, RsE, RtE,
    input  WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW,
    input  MemtoRegE, MemtoRegM,
    output StallF, StallD, FlushE,
    output ForwardAD, ForwardBD,
    output ForwardAE, ForwardBE,
    output MdBusy, StallCnt
  );

endinterface

// File: rtl/hazard_scoreboard_unit_md_busy_tracker.sv
// Mult/div occupancy tracker: busy for MD_LAT-1 cycles
// after each accepted issue.
module md_busy_tracker
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic busy
);

  localparam int CW = $clog2(MD_LAT);

  md_state_e         state_q;
  md_state_e         state_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Issues seen while BUSY are ignored; the hazard logic stalls them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = BUSY;
          cnt_d   = CW'(MD_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit: forwarding selects, load/branch/mult-div
// stall detection and a saturating stall-cycle counter.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic                   clk,
  input logic                   rst,
  hazard_scoreboard_unit_if.slave hz
);

  logic             rs_e_m;
  logic             rs_e_w;
  logic             rt_e_m;
  logic             rt_e_w;
  fwd_sel_e         fwd_ae;
  fwd_sel_e         fwd_be;

  logic             e_hit;
  logic             m_hit;
  logic             lwstall;
  logic             branchstall;
  logic             mdstall;
  logic             stall;

  logic             md_busy;
  logic             md_issue;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign rs_e_m = (hz.RsE != '0) && (hz.RsE == hz.WriteRegM)
                  && hz.RegWriteM;
  assign rs_e_w = (hz.RsE != '0) && (hz.RsE == hz.WriteRegW)
                  && hz.RegWriteW;
  assign rt_e_m = (hz.RtE != '0) && (hz.RtE == hz.WriteRegM)
                  && hz.RegWriteM;
  assign rt_e_w = (hz.RtE != '0) && (hz.RtE == hz.WriteRegW)
                  && hz.RegWriteW;

  assign fwd_ae = fwd_pick(rs_e_m, rs_e_w);
  assign fwd_be = fwd_pick(rt_e_m, rt_e_w);

  assign hz.ForwardAE = fwd_ae;
  assign hz.ForwardBE = fwd_be;

  assign hz.ForwardAD = (hz.RsD != '0) && (hz.RsD == hz.WriteRegM)
                        && hz.RegWriteM;
  assign hz.ForwardBD = (hz.RtD != '0) && (hz.RtD == hz.WriteRegM)
                        && hz.RegWriteM;

  assign lwstall = hz.MemtoRegE && (hz.RtE != '0)
                   && ((hz.RsD == hz.RtE) || (hz.RtD == hz.RtE));

  assign e_hit = hz.RegWriteE && (hz.WriteRegE != '0)
                 && ((hz.WriteRegE == hz.RsD)
                  || (hz.WriteRegE == hz.RtD));
  assign m_hit = hz.MemtoRegM && (hz.WriteRegM != '0)
                 && ((hz.WriteRegM == hz.RsD)
                  || (hz.WriteRegM == hz.RtD));

  assign branchstall = hz.BranchD && (e_hit || m_hit);
  assign mdstall     = md_busy && (hz.MulDivD || hz.HiLoRdD);

  // Stall requests are masked while reset is held.
  assign stall = rst && (lwstall || branchstall || mdstall);

  assign hz.StallF = stall;
  assign hz.StallD = stall;
  assign hz.FlushE = stall;

  assign md_issue = hz.MulDivD && !stall;

  md_busy_tracker #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_tracker (
    .clk   (clk),
    .rst   (rst),
    .issue (md_issue),
    .busy  (md_busy)
  );

  assign hz.MdBusy = md_busy;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign hz.StallCnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed checks for forwarding, stall causes, mult/div
// occupancy, stall counter saturation and reset.
module tb_hazard_scoreboard_unit;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;

  int n_chk;
  int n_fail;
  int exp_cnt;

  hazard_scoreboard_unit_if #(
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) hz ();

  hazard_scoreboard_unit #(
    .REG_AW (REG_AW),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    hz.BranchD   = 1'b0;
    hz.MulDivD   = 1'b0;
    hz.HiLoRdD   = 1'b0;
    hz.RsD       = '0;
    hz.RtD       = '0;
    hz.RsE       = '0;
    hz.RtE       = '0;
    hz.WriteRegE = '0;
    hz.WriteRegM = '0;
    hz.WriteRegW = '0;
    hz.RegWriteE = 1'b0;
    hz.RegWriteM = 1'b0;
    hz.RegWriteW = 1'b0;
    hz.MemtoRegE = 1'b0;
    hz.MemtoRegM = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, ".StallF"}, 32'(hz.StallF), 32'(exp));
    chk({tag, ".StallD"}, 32'(hz.StallD), 32'(exp));
    chk({tag, ".FlushE"}, 32'(hz.FlushE), 32'(exp));
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    exp_cnt = 0;
    rst     = 1'b0;
    clr();

    // Reset: stalls masked, forwarding still live.
    hz.MemtoRegE = 1'b1;
    hz.RtE       = 5'd8;
    hz.RsD       = 5'd8;
    hz.RsE       = 5'd5;
    hz.WriteRegM = 5'd5;
    hz.RegWriteM = 1'b1;
    step();
    step();
    chk_stall("rst_mask", 1'b0);
    chk("rst_busy", 32'(hz.MdBusy), 32'd0);
    chk("rst_cnt", 32'(hz.StallCnt), 32'd0);
    chk("rst_fwd", 32'(hz.ForwardAE), 32'd2);
    clr();
    @(negedge clk);
    rst = 1'b1;
    step();

    // Forwarding selects
    hz.WriteRegM = 5'd5;
    hz.RegWriteM = 1'b1;
    hz.WriteRegW = 5'd5;
    hz.RegWriteW = 1'b1;
    hz.RsE       = 5'd5;
    #1 chk("fae_mem_prio", 32'(hz.ForwardAE), 32'd2);
    hz.RsE = 5'd0;
    #1 chk("fae_r0", 32'(hz.ForwardAE), 32'd0);
    hz.RsE       = 5'd5;
    hz.RegWriteM = 1'b0;
    #1 chk("fae_wb", 32'(hz.ForwardAE), 32'd1);
    hz.RtE       = 5'd5;
    hz.RegWriteM = 1'b1;
    #1 chk("fbe_mem", 32'(hz.ForwardBE), 32'd2);
    hz.WriteRegM = 5'd7;
    #1 chk("fbe_wb", 32'(hz.ForwardBE), 32'd1);
    hz.RegWriteW = 1'b0;
    #1 chk("fbe_none", 32'(hz.ForwardBE), 32'd0);
    hz.RsD       = 5'd7;
    hz.RtD       = 5'd0;
    hz.WriteRegM = 5'd7;
    #1 chk("fad_hit", 32'(hz.ForwardAD), 32'd1);
    hz.WriteRegM = 5'd0;
    #1 chk("fbd_r0", 32'(hz.ForwardBD), 32'd0);
    hz.RtD       = 5'd9;
    hz.WriteRegM = 5'd9;
    #1 chk("fbd_hit", 32'(hz.ForwardBD), 32'd1);
    chk_stall("fwd_nostall", 1'b0);
    clr();
    step();
    chk("cnt_after_fwd", 32'(hz.StallCnt), 32'(exp_cnt));

    // Load-use stall lasts one cycle
    hz.MemtoRegE = 1'b1;
    hz.RtE       = 5'd8;
    hz.RsD       = 5'd8;
    #1 chk_stall("lw_hit", 1'b1);
    step();
    exp_cnt++;
    hz.MemtoRegE = 1'b0;
    #1 chk_stall("lw_gone", 1'b0);
    chk("lw_cnt", 32'(hz.StallCnt), 32'(exp_cnt));
    hz.MemtoRegE = 1'b1;
    hz.RtE       = 5'd0;
    hz.RsD       = 5'd0;
    #1 chk_stall("lw_r0", 1'b0);
    clr();
    step();

    // Branch stall on E, then forward from M
    hz.BranchD   = 1'b1;
    hz.RsD       = 5'd3;
    hz.WriteRegE = 5'd3;
    hz.RegWriteE = 1'b1;
    #1 chk_stall("br_e", 1'b1);
    step();
    exp_cnt++;
    hz.WriteRegE = 5'd0;
    hz.RegWriteE = 1'b0;
    hz.WriteRegM = 5'd3;
    hz.RegWriteM = 1'b1;
    #1 chk_stall("br_m_alu", 1'b0);
    chk("br_fad", 32'(hz.ForwardAD), 32'd1);
    chk("br_cnt", 32'(hz.StallCnt), 32'(exp_cnt));
    hz.MemtoRegM = 1'b1;
    #1 chk_stall("br_m_load", 1'b1);
    clr();
    #1 chk_stall("br_clear", 1'b0);
    step();

    // Mult/div issue, HiLoRdD waits through occupancy
    hz.MulDivD = 1'b1;
    #1 chk_stall("md_issue", 1'b0);
    step();
    hz.MulDivD = 1'b0;
    hz.HiLoRdD = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("md_busy_c%0d", c), 32'(hz.MdBusy), 32'd1);
      chk($sformatf("md_stall_c%0d", c), 32'(hz.StallD), 32'd1);
      step();
      exp_cnt++;
    end
    #1 chk("md_busy_c4", 32'(hz.MdBusy), 32'd0);
    chk("md_stall_c4", 32'(hz.StallD), 32'd0);
    chk("md_cnt", 32'(hz.StallCnt), 32'(exp_cnt));

    // Second mult/div waits, no reload, issues after drop
    hz.HiLoRdD = 1'b0;
    hz.MulDivD = 1'b1;
    step();
    for (int c = 5; c <= 7; c++) begin
      #1;
      chk($sformatf("md2_busy_c%0d", c), 32'(hz.MdBusy), 32'd1);
      chk($sformatf("md2_stall_c%0d", c), 32'(hz.StallD), 32'd1);
      step();
      exp_cnt++;
    end
    #1 chk("md2_busy_c8", 32'(hz.MdBusy), 32'd0);
    chk("md2_stall_c8", 32'(hz.StallD), 32'd0);
    chk("md2_cnt", 32'(hz.StallCnt), 32'(exp_cnt));
    step();
    hz.MulDivD = 1'b0;
    #1 chk("md3_busy", 32'(hz.MdBusy), 32'd1);

    // Reset mid-occupancy, between edges
    #2 rst = 1'b0;
    hz.HiLoRdD = 1'b1;
    #1 chk("mrst_busy", 32'(hz.MdBusy), 32'd0);
    chk("mrst_cnt", 32'(hz.StallCnt), 32'd0);
    chk("mrst_stall", 32'(hz.StallD), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mrel_stall", 32'(hz.StallD), 32'd0);
    step();
    chk("mrel_busy", 32'(hz.MdBusy), 32'd0);
    chk("mrel_stall2", 32'(hz.StallD), 32'd0);
    chk("mrel_cnt", 32'(hz.StallCnt), 32'd0);
    clr();

    // Counter saturation at 15
    hz.MemtoRegE = 1'b1;
    hz.RtE       = 5'd8;
    hz.RsD       = 5'd8;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      if (k == 14 || k == 15 || k == 16 || k == 20)
        chk($sformatf("sat_k%0d", k), 32'(hz.StallCnt),
            32'(exp_cnt));
    end
    chk("sat_final", 32'(hz.StallCnt), 32'd15);
    clr();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-specifier width.
REQ-002 SHALL have parameter MD_LAT, default 4, legal range 2..32, multiply/divide occupancy in cycles.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have ports: BranchD in 1, branch in decode; MulDivD in 1, mult/div in decode; HiLoRdD in 1, mfhi/mflo in decode.
REQ-006 SHALL have ports: RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, each in, REG_AW, register specifiers.
REQ-007 SHALL have ports: RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, each in, 1, stage control.
REQ-008 SHALL have ports: StallF, StallD, FlushE out 1; ForwardAD, ForwardBD out 1; ForwardAE, ForwardBE out 2.
REQ-009 SHALL have ports: MdBusy out 1, mult/div unit occupied; StallCnt out CNT_W, cumulative stall cycles.

Function
REQ-010 ForwardAE SHALL be 2'b10 if RsE!=0, RsE==WriteRegM and RegWriteM; else 2'b01 if RsE!=0, RsE==WriteRegW and RegWriteW; else 2'b00.
REQ-011 ForwardBE SHALL follow REQ-010 with RtE in place of RsE; M has priority over W.
REQ-012 ForwardAD SHALL be (RsD!=0 && RsD==WriteRegM && RegWriteM); ForwardBD likewise with RtD.
REQ-013 lwstall SHALL be MemtoRegE && RtE!=0 && (RsD==RtE || RtD==RtE).
REQ-014 branchstall SHALL be BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE in {RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM in {RsD,RtD})).
REQ-015 mdstall SHALL be MdBusy && (MulDivD || HiLoRdD).
REQ-016 StallF, StallD and FlushE SHALL each equal lwstall || branchstall || mdstall, combinationally.
REQ-017 The occupancy FSM SHALL have states IDLE and BUSY plus a down-counter of width ceil(log2(MD_LAT)).
REQ-018 IDLE -> BUSY SHALL occur at a clock edge where MulDivD=1 and StallD=0; the counter loads MD_LAT-1.
REQ-019 In BUSY the counter SHALL decrement each cycle; BUSY -> IDLE SHALL occur on the edge where the counter is 1.
REQ-020 MdBusy SHALL be 1 exactly in BUSY, so a mult/div issued at edge N asserts MdBusy for cycles N+1..N+MD_LAT-1.
REQ-021 A MulDivD presented while BUSY SHALL be stalled (REQ-015) and SHALL NOT reload the counter.
REQ-022 On the edge BUSY -> IDLE, a waiting MulDivD SHALL NOT issue; it issues on the next edge (MdBusy=0 that cycle).
REQ-023 StallCnt SHALL increment by 1 on each edge where StallD=1 and saturate at 2^CNT_W-1 with no wrap.
REQ-024 Simultaneous stall causes SHALL produce a single stall cycle and a single StallCnt increment.

Reset
REQ-025 rst=0 SHALL, asynchronously, force state IDLE, counter 0, StallCnt 0 and MdBusy 0.
REQ-026 While rst=0, StallF, StallD and FlushE SHALL be 0 regardless of inputs; forwarding outputs remain combinational.
REQ-027 Reset asserted mid-BUSY SHALL abandon the occupancy with no pending state retained after release.

Structure
REQ-028 Forward-select encodings FWD_NONE=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10, plus the FSM state enum, SHALL live in the shared pipeline package.
REQ-029 The occupancy FSM and counter SHALL be one sub-module, md_busy_tracker (ports clk, rst, issue, busy).

Verification
REQ-030 Case WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1, RsE=5 -> ForwardAE=2'b10; with RsE=0 -> 2'b00.
REQ-031 Case MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for exactly one cycle; with RtE=0 -> no stall.
REQ-032 Case BranchD=1, RsD=3, WriteRegE=3, RegWriteE=1 -> stall; next cycle (WriteRegM=3, MemtoRegM=0) -> no stall and ForwardAD=1.
REQ-033 Case MD_LAT=4, MulDivD issued at edge 0, HiLoRdD held from cycle 1 -> MdBusy high during cycles 1-3, StallD high during cycles 1-3, low in cycle 4.
REQ-034 Case StallD held high, CNT_W=4, for 20 cycles -> StallCnt reaches 15 and holds at 15.
REQ-035 Case rst driven low mid-BUSY between clock edges -> MdBusy=0 and StallCnt=0 immediately; after release, HiLoRdD=1 -> no stall.
